// File: rtl/usb3_phy_bringup_seq_if.sv
// Handshake/status bundle between the PHY bring-up sequencer and the top level.
// master = sequencer side, slave = PLL/PHY/LTSSM side.
interface usb3_phy_bringup_seq_if #(
  parameter int STRAP_W = 5
);
  logic               pll_locked;
  logic               phy_pwrpresent;
  logic               warm_reset_req;
  logic               phy_reset_n;
  logic [STRAP_W-1:0] strap_oe;
  logic [STRAP_W-1:0] strap_out;
  logic               local_reset_n;
  logic               ready;
  logic [2:0]         seq_state;
  logic [7:0]         fault_count;

  modport master (
    input  pll_locked,
    input  phy_pwrpresent,
    input  warm_reset_req,
    output phy_reset_n,
    output strap_oe,
    output strap_out,
    output local_reset_n,
    output ready,
    output seq_state,
    output fault_count
  );

  modport slave (
    output pll_locked,
    output phy_pwrpresent,
    output warm_reset_req,
    input  phy_reset_n,
    input  strap_oe,
    input  strap_out,
    input  local_reset_n,
    input  ready,
    input  seq_state,
    input  fault_count
  );
endinterface

// File: rtl/usb3_phy_bringup_seq.sv
// USB3 PIPE PHY power-up/reset/strap sequencer: qualifies PLL lock and
// VBUS, pulses PHY reset, holds straps across release, then frees the core.
module usb3_phy_bringup_seq #(
  parameter int                 STRAP_W           = 5,
  parameter logic [STRAP_W-1:0] STRAP_VALUE       = 5'b00110,
  parameter int                 SYNC_STAGES       = 2,
  parameter int                 DEBOUNCE_CYCLES   = 64,
  parameter int                 RESET_CYCLES      = 150,
  parameter int                 STRAP_HOLD_CYCLES = 8,
  parameter int                 RELEASE_CYCLES    = 4,
  parameter int                 CNT_W             = 16
) (
  input  logic                   local_clk,
  input  logic                   reset_n,
  usb3_phy_bringup_seq_if.master bus
);

  typedef enum logic [2:0] {
    WAIT_GOOD  = 3'd0,
    PHY_RST    = 3'd1,
    STRAP_HOLD = 3'd2,
    RELEASE    = 3'd3,
    RUN        = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(STRAP_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST =
    CNT_W'(RELEASE_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SYNC_STAGES-1:0] pll_sync;
  logic [SYNC_STAGES-1:0] pwr_sync;
  logic               good;
  logic               lost;

  logic               phy_reset_n_q;
  logic [STRAP_W-1:0] strap_oe_q;
  logic [STRAP_W-1:0] strap_out_q;
  logic               local_reset_n_q;
  logic               ready_q;
  logic [7:0]         fault_q;

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_sync <= '0;
      pwr_sync <= '0;
    end else begin
      pll_sync <= {pll_sync[SYNC_STAGES-2:0], bus.pll_locked};
      pwr_sync <= {pwr_sync[SYNC_STAGES-2:0], bus.phy_pwrpresent};
    end
  end

  assign good = pll_sync[SYNC_STAGES-1] & pwr_sync[SYNC_STAGES-1];
  // Loss of good while idle in WAIT_GOOD is just debounce, not a fault.
  assign lost = !good && (state != WAIT_GOOD);

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= WAIT_GOOD;
      cnt             <= '0;
      phy_reset_n_q   <= 1'b0;
      strap_oe_q      <= '1;
      strap_out_q     <= STRAP_VALUE;
      local_reset_n_q <= 1'b0;
      ready_q         <= 1'b0;
      fault_q         <= 8'd0;
    end else begin
      strap_out_q <= STRAP_VALUE;
      cnt         <= cnt + CNT_W'(1);
      if (lost) begin
        state           <= WAIT_GOOD;
        cnt             <= '0;
        phy_reset_n_q   <= 1'b0;
        strap_oe_q      <= '1;
        local_reset_n_q <= 1'b0;
        ready_q         <= 1'b0;
        if (fault_q != 8'hFF)
          fault_q <= fault_q + 8'd1;
      end else begin
        unique case (state)
          WAIT_GOOD: begin
            if (!good) begin
              cnt <= '0;
            end else if (cnt == DEB_LAST) begin
              state <= PHY_RST;
              cnt   <= '0;
            end
          end
          PHY_RST: begin
            if (cnt == RST_LAST) begin
              state         <= STRAP_HOLD;
              cnt           <= '0;
              phy_reset_n_q <= 1'b1;
            end
          end
          STRAP_HOLD: begin
            if (cnt == HOLD_LAST) begin
              state      <= RELEASE;
              cnt        <= '0;
              strap_oe_q <= '0;
            end
          end
          RELEASE: begin
            if (cnt == REL_LAST) begin
              state           <= RUN;
              cnt             <= '0;
              local_reset_n_q <= 1'b1;
              ready_q         <= 1'b1;
            end
          end
          RUN: begin
            // Warm reset skips debounce: good is already qualified.
            if (bus.warm_reset_req) begin
              state           <= PHY_RST;
              cnt             <= '0;
              phy_reset_n_q   <= 1'b0;
              strap_oe_q      <= '1;
              local_reset_n_q <= 1'b0;
              ready_q         <= 1'b0;
            end
          end
          default: begin
            state           <= WAIT_GOOD;
            cnt             <= '0;
            phy_reset_n_q   <= 1'b0;
            strap_oe_q      <= '1;
            local_reset_n_q <= 1'b0;
            ready_q         <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.phy_reset_n   = phy_reset_n_q;
  assign bus.strap_oe      = strap_oe_q;
  assign bus.strap_out     = strap_out_q;
  assign bus.local_reset_n = local_reset_n_q;
  assign bus.ready         = ready_q;
  assign bus.seq_state     = state;
  assign bus.fault_count   = fault_q;

endmodule
